// File: rtl/sound_mixer.sv
// Four-channel stereo mixer: two-stage pan/sum then master-volume pipeline at the sample rate.
// Optional first-order sigma-delta DAC outputs are compiled in with SOUND_MIXER_PWM_EN.
module sound_mixer #(
    parameter int SAMPLE_DIV = 95
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [4:0]        iCh1,
    input  logic [4:0]        iCh2,
    input  logic [4:0]        iCh3,
    input  logic [4:0]        iCh4,
    input  logic [7:0]        iNR50,
    input  logic [7:0]        iNR51,
    input  logic [7:0]        iNR52,
    output logic signed [9:0] oLeft,
    output logic signed [9:0] oRight,
    output logic              oSampleValid,
    output logic              oPwmLeft,
    output logic              oPwmRight
);

    localparam logic [7:0] LAST = 8'(SAMPLE_DIV - 1);

    logic              enable;
    logic [7:0]        sdiv;
    logic              strobe;
    logic [4:0]        ch [4];
    logic [4:0]        clamped;
    logic signed [6:0] level;
    logic signed [6:0] sum_l_next;
    logic signed [6:0] sum_r_next;

    logic signed [6:0] sum_l;
    logic signed [6:0] sum_r;
    logic [3:0]        mult_l;
    logic [3:0]        mult_r;
    logic              stage1_valid;
    logic              stage2_valid;

    logic signed [9:0] sum_l_ext;
    logic signed [9:0] sum_r_ext;
    logic signed [9:0] mult_l_ext;
    logic signed [9:0] mult_r_ext;

    logic              unused_bits;

    assign enable      = iNR52[7];
    assign strobe      = (sdiv == LAST);
    assign ch[0]       = iCh1;
    assign ch[1]       = iCh2;
    assign ch[2]       = iCh3;
    assign ch[3]       = iCh4;
    assign unused_bits = ^{iNR50[7], iNR50[3], iNR52[6:0]};

    // Clamp each channel to 30, recentre around silence, and route it by NR51.
    always_comb begin
        clamped    = '0;
        level      = '0;
        sum_l_next = '0;
        sum_r_next = '0;
        for (int i = 0; i < 4; i++) begin
            clamped = (ch[i] > 5'd30) ? 5'd30 : ch[i];
            level   = $signed({2'b00, clamped}) - 7'sd15;
            if (iNR51[i + 4]) sum_l_next = sum_l_next + level;
            if (iNR51[i])     sum_r_next = sum_r_next + level;
        end
    end

    assign sum_l_ext  = {{3{sum_l[6]}}, sum_l};
    assign sum_r_ext  = {{3{sum_r[6]}}, sum_r};
    assign mult_l_ext = $signed({6'b000000, mult_l});
    assign mult_r_ext = $signed({6'b000000, mult_r});

    // Disabling sound behaves like a synchronous clear, so re-enabling restarts the divider.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            sdiv         <= '0;
            sum_l        <= '0;
            sum_r        <= '0;
            mult_l       <= '0;
            mult_r       <= '0;
            stage1_valid <= 1'b0;
            stage2_valid <= 1'b0;
            oLeft        <= '0;
            oRight       <= '0;
            oSampleValid <= 1'b0;
        end else if (!enable) begin
            sdiv         <= '0;
            sum_l        <= '0;
            sum_r        <= '0;
            mult_l       <= '0;
            mult_r       <= '0;
            stage1_valid <= 1'b0;
            stage2_valid <= 1'b0;
            oLeft        <= '0;
            oRight       <= '0;
            oSampleValid <= 1'b0;
        end else begin
            sdiv         <= strobe ? 8'd0 : sdiv + 8'd1;
            stage1_valid <= strobe;
            if (strobe) begin
                sum_l  <= sum_l_next;
                sum_r  <= sum_r_next;
                mult_l <= {1'b0, iNR50[6:4]} + 4'd1;
                mult_r <= {1'b0, iNR50[2:0]} + 4'd1;
            end
            stage2_valid <= stage1_valid;
            if (stage1_valid) begin
                oLeft  <= sum_l_ext * mult_l_ext;
                oRight <= sum_r_ext * mult_r_ext;
            end
            oSampleValid <= stage2_valid;
        end
    end

`ifdef SOUND_MIXER_PWM_EN
    logic [10:0] acc_l;
    logic [10:0] acc_r;
    logic [9:0]  u_l;
    logic [9:0]  u_r;

    // Adding 512 to a 10-bit two's-complement value is just an MSB flip.
    assign u_l = {~oLeft[9], oLeft[8:0]};
    assign u_r = {~oRight[9], oRight[8:0]};

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            acc_l     <= '0;
            acc_r     <= '0;
            oPwmLeft  <= 1'b0;
            oPwmRight <= 1'b0;
        end else if (!enable) begin
            acc_l     <= '0;
            acc_r     <= '0;
            oPwmLeft  <= 1'b0;
            oPwmRight <= 1'b0;
        end else begin
            acc_l     <= {1'b0, acc_l[9:0]} + {1'b0, u_l};
            acc_r     <= {1'b0, acc_r[9:0]} + {1'b0, u_r};
            oPwmLeft  <= acc_l[10];
            oPwmRight <= acc_r[10];
        end
    end
`else
    assign oPwmLeft  = 1'b0;
    assign oPwmRight = 1'b0;
`endif

endmodule

// File: doc/sound_mixer.md
SOUND_MIXER -- requirements
Module: sound_mixer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 95, iClock cycles per output sample (about 44.15 kHz at 4194304 Hz); legal range 3..255.
REQ-002 SHALL have port iClock  input  1  CPU clock, 4194304 Hz; all state updates on its rising edge.
REQ-003 SHALL have port iReset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports iCh1..iCh4  input  5 each  channel outputs, offset-binary with silence at 15 and valid range 0..30.
REQ-005 SHALL have port iNR50  input  8  master volume: [6:4] left, [2:0] right; bits 7 and 3 (Vin) ignored.
REQ-006 SHALL have port iNR51  input  8  panning: [7:4] ch4..ch1 to left; [3:0] ch4..ch1 to right.
REQ-007 SHALL have port iNR52  input  8  bit 7 is master sound enable; other bits ignored.
REQ-008 SHALL have ports oLeft, oRight  output  10 each  signed two's-complement mixed samples.
REQ-009 SHALL have port oSampleValid  output  1  one-cycle pulse when oLeft/oRight update.
REQ-010 SHALL have ports oPwmLeft, oPwmRight  output  1 each  1-bit sigma-delta DAC streams.

Function
REQ-011 SHALL run divider sdiv over 0..SAMPLE_DIV-1, wrapping to 0; internal strobe asserts in the cycle sdiv==SAMPLE_DIV-1.
REQ-012 Stage 1 (strobe cycle) SHALL clamp each iChN to at most 30, compute sN = iChN-15 (signed, -15..+15), and capture iNR50/iNR51.
REQ-013 Stage 1 SHALL register sumL = sum of sN with NR51[N+3] set and sumR = sum of sN with NR51[N-1] set, each 7-bit signed (-60..+60); no channel selected gives 0.
REQ-014 Stage 2 (next cycle) SHALL register oLeft = sumL*(NR50[6:4]+1) and oRight = sumR*(NR50[2:0]+1), range -480..+480, no saturation needed.
REQ-015 oSampleValid SHALL pulse high in the cycle after stage 2 loads, i.e. 2 cycles after the strobe; it is never high two cycles in a row.
REQ-016 NR50/NR51/iChN changes outside the strobe cycle SHALL NOT affect the sample in flight.
REQ-017 While iNR52[7]==0: sdiv, pipeline, oLeft, oRight and oSampleValid held at 0; DAC accumulators held at reset value; oPwmLeft/oPwmRight held at 0.
REQ-018 When iNR52[7] rises, sdiv SHALL restart from 0; the first strobe comes SAMPLE_DIV-1 cycles after the rising-edge cycle.

Reset
REQ-019 iReset SHALL asynchronously clear sdiv, both pipeline stages, oLeft, oRight, oSampleValid, oPwmLeft, oPwmRight and both DAC accumulators to 0.
REQ-020 Reset asserted mid-pipeline SHALL discard the in-flight sample; no oSampleValid for it after release.

Configuration
REQ-021 Macro SOUND_MIXER_PWM_EN defined SHALL compile in two first-order sigma-delta DACs, one per side, each updated every cycle as follows:
- u = oLeft+512 (or oRight+512), 10-bit unsigned, range 32..992.
- acc (11 bits) <= {1'b0, acc[9:0]} + u.
- Output = acc[10], registered.
- Long-run ones density = u/1024.
REQ-022 Macro SOUND_MIXER_PWM_EN undefined SHALL exclude the DAC logic and tie oPwmLeft/oPwmRight to 0; all other behaviour is unchanged.

Verification
REQ-023 Reset release, NR52=0x80, SAMPLE_DIV=95: first oSampleValid exactly 96 clocks after release (strobe at edge 94, output at edge 96 counting from edge 0), then every 95 clocks.
REQ-024 All iCh=30, NR51=0xFF, NR50=0x77 -> oLeft=oRight=+480; all iCh=0 -> oLeft=oRight=-480.
REQ-025 iCh1=0, iCh2..4=15, NR51=0x10, NR50=0x70 -> oLeft=-120, oRight=0; iCh1=31 with NR51=0x01 and NR50=0x00 -> oRight=+15 (clamped).
REQ-026 NR51 changed in the cycle after the strobe -> the current sample uses the old NR51 and the next sample uses the new value.
REQ-027 SOUND_MIXER_PWM_EN defined with steady oLeft=0 -> exactly 512 ones on oPwmLeft in any 1024-cycle window after settling; oLeft=+480 -> 992 ones.
REQ-028 NR52[7] cleared mid-pipeline, then iReset pulsed -> all outputs 0 within one cycle and no stray oSampleValid.
